// File: rtl/uart_mm_pkg.sv
// Shared state encoding, opcodes and error codes for the UART memory-mapped burst bridge.
// Defining UART_MM_CHECKSUM_EN adds the checksum response state.
package uart_mm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR  = 4'd1,
    ST_LEN   = 4'd2,
    ST_WDATA = 4'd3,
    ST_WRITE = 4'd4,
    ST_RREQ  = 4'd5,
    ST_RSEND = 4'd6,
    ST_ACK   = 4'd7
`ifdef UART_MM_CHECKSUM_EN
    , ST_CSUM = 4'd8
`endif
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h06;

  localparam logic [1:0] ERR_OP      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  // States in which an incoming byte cannot be consumed and is reported as overrun.
  function automatic logic rx_blocked(input state_e s);
    case (s)
      ST_WRITE, ST_RREQ, ST_RSEND, ST_ACK: return 1'b1;
`ifdef UART_MM_CHECKSUM_EN
      ST_CSUM: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_mm_timeout_cnt.sv
// Inter-byte timeout: down-counter reloaded on load_i, expire_o flags the final idle cycle.
module uart_mm_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic en_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: reload, count down while enabled, saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = RELOAD;
    end else if (en_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && !load_i && (count_q == {W{1'b0}});

endmodule

// File: rtl/uart_mm_burst_bridge.sv
// UART byte-stream to memory-mapped bus bridge with burst read/write, ack and error reporting.
// Optional macro UART_MM_CHECKSUM_EN appends an XOR checksum byte to every response.
module uart_mm_burst_bridge
  import uart_mm_pkg::*;
#(
  parameter int NUM_BYTES_DATA    = 4,
  parameter int NUM_BYTES_ADDRESS = 1,
  parameter int TIMEOUT_CYCLES    = 100000
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           tx_valid,
  output logic [7:0]                     tx_data,
  input  logic                           tx_ready,
  output logic                           mem_we,
  output logic [NUM_BYTES_DATA*8-1:0]    mem_wdata,
  output logic [NUM_BYTES_ADDRESS*8-1:0] mem_waddr,
  output logic                           mem_re,
  output logic [NUM_BYTES_ADDRESS*8-1:0] mem_raddr,
  input  logic [NUM_BYTES_DATA*8-1:0]    mem_rdata,
  input  logic                           mem_rdy,
  output logic                           busy,
  output logic                           err,
  output logic [1:0]                     err_code
);

  localparam int DW = NUM_BYTES_DATA * 8;
  localparam int AW = NUM_BYTES_ADDRESS * 8;
  localparam logic [3:0] NBD_LAST = 4'(NUM_BYTES_DATA - 1);
  localparam logic [3:0] NBA_LAST = 4'(NUM_BYTES_ADDRESS - 1);
`ifdef UART_MM_CHECKSUM_EN
  localparam state_e RESP_END = ST_CSUM;
`else
  localparam state_e RESP_END = ST_IDLE;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      words_left_q, words_left_d;
  logic            is_read_q, is_read_d;
  logic            mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            err_q, err_d, busy_q, busy_d;
  logic [1:0]      err_code_q, err_code_d;
`ifdef UART_MM_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif
  logic            tmo_en_s, tmo_load_s, tmo_expire_s;

  assign tmo_en_s   = (state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_WDATA);
  assign tmo_load_s = rx_valid || !tmo_en_s;

  uart_mm_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .en_i    (tmo_en_s),
    .load_i  (tmo_load_s),
    .expire_o(tmo_expire_s)
  );

  // Frame FSM: next state, datapath updates and registered output values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    is_read_d    = is_read_q;
    mem_we_d     = mem_we_q;
    mem_re_d     = mem_re_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
`ifdef UART_MM_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
          is_read_d  = (rx_data == OP_READ);
          byte_cnt_d = 4'd0;
          state_d    = ST_ADDR;
        end else if (rx_valid) begin
          err_d      = 1'b1;
          err_code_d = ERR_OP;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d = (addr_q << 4'd8) | AW'(rx_data);
          if (byte_cnt_q == NBA_LAST) begin
            byte_cnt_d = 4'd0;
            state_d    = ST_LEN;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          words_left_d = rx_data;
          byte_cnt_d   = 4'd0;
          state_d      = is_read_q ? ST_RREQ : ST_WDATA;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_WDATA: begin
        if (rx_valid) begin
          data_d = (data_q << 4'd8) | DW'(rx_data);
          if (byte_cnt_q == NBD_LAST) begin
            byte_cnt_d = 4'd0;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WRITE: begin
        // mem_rdy only counts once the request is actually on the bus.
        if (mem_we_q && mem_rdy) begin
          mem_we_d = 1'b0;
          addr_d   = addr_q + AW'(1'b1);
          if (words_left_q == 8'd0) begin
            state_d = ST_ACK;
          end else begin
            words_left_d = words_left_q - 8'd1;
            state_d      = ST_WDATA;
          end
        end else begin
          mem_we_d = 1'b1;
        end
      end
      ST_RREQ: begin
        if (mem_re_q && mem_rdy) begin
          mem_re_d   = 1'b0;
          data_d     = mem_rdata;
          byte_cnt_d = 4'd0;
          state_d    = ST_RSEND;
        end else begin
          mem_re_d = 1'b1;
        end
      end
      ST_RSEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = data_q[DW-1 -: 8];
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          data_d     = data_q << 4'd8;
          if (byte_cnt_q == NBD_LAST) begin
            byte_cnt_d = 4'd0;
            addr_d     = addr_q + AW'(1'b1);
            if (words_left_q == 8'd0) begin
              state_d = RESP_END;
            end else begin
              words_left_d = words_left_q - 8'd1;
              state_d      = ST_RREQ;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      ST_ACK: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = RESP_END;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
`ifdef UART_MM_CHECKSUM_EN
      ST_CSUM: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = csum_q;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timeout abandons the frame; an overrun byte is dropped but the burst continues.
    if (tmo_expire_s) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      byte_cnt_d = 4'd0;
      state_d    = ST_IDLE;
    end else if (rx_valid && rx_blocked(state_q)) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERRUN;
    end else begin
      err_code_d = err_code_d;
    end

`ifdef UART_MM_CHECKSUM_EN
    if (state_d == ST_IDLE) begin
      csum_d = 8'h00;
    end else if (tx_valid_q && tx_ready) begin
      csum_d = csum_q ^ tx_data_q;
    end else begin
      csum_d = csum_q;
    end
`endif
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= {AW{1'b0}};
      data_q       <= {DW{1'b0}};
      byte_cnt_q   <= 4'd0;
      words_left_q <= 8'd0;
      is_read_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      busy_q       <= 1'b0;
`ifdef UART_MM_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      is_read_q    <= is_read_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
`ifdef UART_MM_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = data_q;
  assign mem_waddr = addr_q;
  assign mem_re    = mem_re_q;
  assign mem_raddr = addr_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_mm_burst_bridge.sv
// Randomized self-checking bench for uart_mm_burst_bridge against a frame-level reference model.
// Honours UART_MM_CHECKSUM_EN when building the expected response bytes.
module tb_uart_mm_burst_bridge;

  localparam int NBD = 4;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_we, mem_re, busy, err;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rdy = 1'b0;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_mm_burst_bridge #(
    .NUM_BYTES_DATA(NBD), .NUM_BYTES_ADDRESS(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .arst_n(arst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .busy(busy), .err(err), .err_code(err_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: expected bus accesses and tx bytes, plus the memory image.
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [7:0]  exp_ra[$];
  logic [31:0] ref_mem[256];
  logic [31:0] slave_mem[256];
  int wr_done = 0, rd_done = 0, err_cnt = 0;
  bit hold_rdy = 1'b0, bp_hold = 1'b0;

  logic p_we = 1'b0, p_re = 1'b0, p_rdy = 1'b0, p_txv = 1'b0, p_txr = 1'b0;
  logic [7:0]  p_waddr = 8'h0, p_raddr = 8'h0, p_txd = 8'h0;
  logic [31:0] p_wdata = 32'h0;

  // Memory slave and tx sink: sample #1 after each edge, then drive the next cycle's inputs.
  always begin
    @(posedge clk); #1;
    if (p_we && p_rdy) begin
      wr_done++;
      slave_mem[p_waddr] = p_wdata;
      chk_eq("wr_expected", exp_wa.size() > 0, 1'b1);
      if (exp_wa.size() > 0) begin
        chk_eq("waddr", p_waddr, exp_wa.pop_front());
        chk_eq("wdata", p_wdata, exp_wd.pop_front());
      end
    end
    if (p_re && p_rdy) begin
      rd_done++;
      chk_eq("rd_expected", exp_ra.size() > 0, 1'b1);
      if (exp_ra.size() > 0) chk_eq("raddr", p_raddr, exp_ra.pop_front());
    end
    if (mem_we || mem_re) chk_eq("we_re_excl", mem_we & mem_re, 1'b0);
    if (p_txv && p_txr) begin
      chk_eq("tx_expected", exp_tx.size() > 0, 1'b1);
      if (exp_tx.size() > 0) chk_eq("tx_byte", p_txd, exp_tx.pop_front());
    end else if (p_txv && arst_n) begin
      chk_eq("tx_hold_valid", tx_valid, 1'b1);
      chk_eq("tx_hold_data", tx_data, p_txd);
    end
    if (err) err_cnt++;
    mem_rdy   = hold_rdy ? 1'b0 : ($urandom_range(0, 1) == 1);
    mem_rdata = mem_re ? slave_mem[mem_raddr] : 32'($urandom);
    tx_ready  = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    p_we = mem_we; p_re = mem_re; p_rdy = mem_rdy; p_waddr = mem_waddr; p_wdata = mem_wdata;
    p_raddr = mem_raddr; p_txv = tx_valid; p_txr = tx_ready; p_txd = tx_data;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int gmax);
    step($urandom_range(0, gmax));
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (!(exp_tx.size() == 0 && exp_wa.size() == 0 && exp_ra.size() == 0 && busy == 1'b0)
           && cyc < budget) begin
      step(1); cyc++;
    end
    chk_eq("frame_done", cyc < budget, 1'b1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] len, input int gmax,
                          input bit fixed, input logic [31:0] fixed_w);
    logic [31:0] w;
    logic [7:0]  ad;
    int start = wr_done;
    int cyc;
    exp_tx.push_back(8'h06);
`ifdef UART_MM_CHECKSUM_EN
    exp_tx.push_back(8'h06);
`endif
    rx_byte(8'h57); gap(gmax); rx_byte(a); gap(gmax); rx_byte(len);
    for (int i = 0; i <= int'(len); i++) begin
      w  = fixed ? fixed_w : 32'($urandom);
      ad = a + 8'(i);
      ref_mem[ad] = w;
      exp_wa.push_back(ad);
      exp_wd.push_back(w);
      for (int b = NBD - 1; b >= 0; b--) begin
        gap(gmax);
        rx_byte(w[b*8 +: 8]);
      end
      cyc = 0;
      while (wr_done < start + i + 1 && cyc < 300) begin step(1); cyc++; end
      chk_eq("wr_pace", wr_done >= start + i + 1, 1'b1);
    end
    wait_done(2000);
  endtask

  task automatic start_read(input logic [7:0] a, input logic [7:0] len, input int gmax);
    logic [7:0] cs = 8'h00;
    logic [7:0] ad;
    logic [31:0] w;
    for (int i = 0; i <= int'(len); i++) begin
      ad = a + 8'(i);
      exp_ra.push_back(ad);
      w = ref_mem[ad];
      for (int b = NBD - 1; b >= 0; b--) begin
        exp_tx.push_back(w[b*8 +: 8]);
        cs = cs ^ w[b*8 +: 8];
      end
    end
`ifdef UART_MM_CHECKSUM_EN
    exp_tx.push_back(cs);
`endif
    rx_byte(8'h52); gap(gmax); rx_byte(a); gap(gmax); rx_byte(len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc, first_k, err_base;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 32'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    step(3);
    chk_eq("rst_tx_valid", tx_valid, 1'b0);
    chk_eq("rst_mem_we", mem_we, 1'b0);
    chk_eq("rst_mem_re", mem_re, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_err", {err, err_code}, 3'b000);
    chk_eq("rst_outs", {tx_data, mem_waddr, mem_raddr, mem_wdata}, 56'h0);
    arst_n = 1'b1;
    step(2);

    // Single write of a known word.
    do_write(8'h10, 8'h00, 0, 1'b1, 32'hDEADBEEF);
    chk_eq("single_write_mem", slave_mem[8'h10], 32'hDEADBEEF);

    // Burst read across the address wrap.
    slave_mem[8'hFE] = 32'h11111111; ref_mem[8'hFE] = 32'h11111111;
    slave_mem[8'hFF] = 32'h22222222; ref_mem[8'hFF] = 32'h22222222;
    slave_mem[8'h00] = 32'h33333333; ref_mem[8'h00] = 32'h33333333;
    start_read(8'hFE, 8'h02, 0);
    wait_done(2000);

    // Bad opcode.
    base = wr_done + rd_done;
    rx_byte(8'h41);
    chk_eq("badop_err", err, 1'b1);
    chk_eq("badop_code", err_code, 2'd1);
    chk_eq("badop_busy", busy, 1'b0);
    step(1);
    chk_eq("badop_pulse", err, 1'b0);
    chk_eq("badop_busy2", busy, 1'b0);
    chk_eq("badop_nomem", wr_done + rd_done, base);

    // Timeout after the address byte.
    base = wr_done;
    first_k = -1;
    rx_byte(8'h57); rx_byte(8'h10);
    for (int k = 1; k <= 25; k++) begin
      step(1);
      if (err && first_k < 0) first_k = k;
    end
    chk_eq("tmo_cycle", first_k, TMO);
    chk_eq("tmo_code", err_code, 2'd2);
    chk_eq("tmo_busy", busy, 1'b0);
    chk_eq("tmo_nowrite", wr_done, base);

    // Backpressure for 50 cycles in RSEND, with an overrun byte in the middle.
    bp_hold = 1'b1;
    start_read(8'h30, 8'h01, 0);
    cyc = 0;
    while (!tx_valid && cyc < 200) begin step(1); cyc++; end
    chk_eq("bp_tx_seen", tx_valid, 1'b1);
    step(10);
    rx_byte(8'h00);
    chk_eq("ovr_err", err, 1'b1);
    chk_eq("ovr_code", err_code, 2'd3);
    step(39);
    bp_hold = 1'b0;
    wait_done(2000);

    // Randomized frames.
    err_base = err_cnt;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(8'($urandom), 8'($urandom_range(0, 5)), 3, 1'b0, 32'h0);
      end else begin
        start_read(8'($urandom), 8'($urandom_range(0, 5)), 3);
        wait_done(3000);
      end
    end
    chk_eq("rand_no_err", err_cnt, err_base);

    // Reset while a read request is stalled.
    hold_rdy = 1'b1;
    start_read(8'h40, 8'h00, 0);
    cyc = 0;
    while (!mem_re && cyc < 50) begin step(1); cyc++; end
    chk_eq("rst_mid_re_seen", mem_re, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk_eq("rst_mid_re", mem_re, 1'b0);
    chk_eq("rst_mid_txv", tx_valid, 1'b0);
    chk_eq("rst_mid_busy", busy, 1'b0);
    exp_tx.delete(); exp_ra.delete();
    step(2);
    arst_n = 1'b1;
    hold_rdy = 1'b0;
    step(2);
    start_read(8'h00, 8'h00, 0);
    wait_done(2000);

    chk_eq("tail_queues", exp_tx.size() + exp_wa.size() + exp_ra.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mm_burst_bridge.md
Name: uart_mm_burst_bridge

Overview:
- Byte-stream command bridge between a UART byte interface and a simple memory-mapped bus. Successor to the single-access memory-mapped UART path.
- Generalised to parametrised data and address widths. Adds burst read/write with address auto-increment, write acknowledge, inter-byte timeout and error reporting.
- Sits between the UART rx/tx byte ports and the memory port of the memory-mapped UART top level.

Parameters:
- NUM_BYTES_DATA, 4, bytes per memory word (1..8); words are sent on the wire MSB first.
- NUM_BYTES_ADDRESS, 1, bytes per address (1..4); sent on the wire MSB first.
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between rx bytes inside a frame (>= 2).

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  byte available for the UART transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
- mem_we  out  1  write request, held until mem_rdy
- mem_wdata  out  NUM_BYTES_DATA*8  write data
- mem_waddr  out  NUM_BYTES_ADDRESS*8  write address
- mem_re  out  1  read request, held until mem_rdy
- mem_raddr  out  NUM_BYTES_ADDRESS*8  read address
- mem_rdata  in  NUM_BYTES_DATA*8  read data, valid in the cycle mem_rdy is high
- mem_rdy  in  1  completes the pending mem_we or mem_re access
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on bad opcode, timeout or overrun
- err_code  out  2  cause of the last error: 1 = opcode, 2 = timeout, 3 = overrun; holds until the next error

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; all counters and shift registers are 0.
  - arst_n asserted mid-frame aborts immediately: no pending mem_we/mem_re and no tx_valid survive.
- Frame format: OP, ADDR[NBA bytes], LEN, then payload.
  - Burst length = LEN+1 words (1..256).
  - OP 0x57 ('W'): host sends (LEN+1)*NBD data bytes.
  - OP 0x52 ('R'): bridge returns (LEN+1)*NBD bytes.
- States: IDLE, ADDR, LEN, WDATA, WRITE, RREQ, RSEND, ACK.
  - IDLE: on rx 0x57 or 0x52, latch OP and go to ADDR. Any other byte: err pulse, err_code=1, stay IDLE.
  - ADDR: shift in NBA bytes, MSB first; after the last byte go to LEN.
  - LEN: latch LEN. Write goes to WDATA; read goes to RREQ.
  - WDATA: shift in NBD bytes; after the last byte go to WRITE.
  - WRITE: mem_we=1 with mem_waddr=addr and mem_wdata=word, held until mem_rdy.
    - On mem_rdy: addr increments. If words remain, go to WDATA; otherwise go to ACK.
  - ACK: tx_data=0x06, tx_valid held until tx_ready, then go to IDLE.
  - RREQ: mem_re=1 with mem_raddr=addr, held until mem_rdy. On mem_rdy, capture mem_rdata and go to RSEND.
  - RSEND: send NBD bytes MSB first, each byte handshaked on tx_valid/tx_ready.
    - After the last byte: addr increments. If words remain, go to RREQ; otherwise go to IDLE.
- Handshake timing:
  - mem_we/mem_re rise in the cycle after entering WRITE/RREQ (registered) and drop in the cycle after mem_rdy.
  - mem_rdy is ignored when no request is pending.
  - mem_we and mem_re are never high together.
- Address increment wraps modulo 2^(8*NBA); for example 0xFF+1 = 0x00 with NBA=1.
- Timeout:
  - In ADDR, LEN and WDATA, a counter reloads on every rx_valid.
  - Reaching TIMEOUT_CYCLES: err pulse, err_code=2, go to IDLE. Words already written stay written.
- Overrun: rx_valid in WRITE, RREQ, RSEND or ACK drops the byte and raises err with err_code=3. The burst itself continues.
- Back-to-back: rx_valid in the same cycle as the return to IDLE is taken as a new OP.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: UART_MM_CHECKSUM_EN.
- Defined:
  - The bridge keeps an 8-bit XOR of every byte it transmits in the current response.
  - After the last read data byte, or after the 0x06 ack, it sends one extra checksum byte before returning to IDLE. The ack checksum is 0x06.
  - The XOR register clears on entering IDLE.
- Undefined: no checksum byte and no XOR register.

Decomposition:
- Package uart_mm_pkg holds:
  - state enum typedef;
  - OP_WRITE=8'h57, OP_READ=8'h52, ACK_BYTE=8'h06;
  - err_code localparams ERR_OP=2'd1, ERR_TIMEOUT=2'd2, ERR_OVERRUN=2'd3.
- One sub-module, uart_mm_timeout_cnt: loadable down-counter with reload and expire pulse, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Single write (defaults): rx 57 10 00 DE AD BE EF.
  - Expect one mem_we with waddr=0x10 and wdata=0xDEADBEEF.
  - Then tx 0x06 (0x06,0x06 with checksum).
- Burst read with wrap: rx 52 FE 02, mem_rdata = 0x11111111, 0x22222222, 0x33333333.
  - Expect raddr 0xFE, 0xFF, 0x00.
  - tx 11 11 11 11 22 22 22 22 33 33 33 33; with checksum, extra byte 0x00.
- tx backpressure: tx_ready low for 50 cycles during RSEND.
  - tx_valid and tx_data stay stable; no byte is lost or duplicated.
- Bad opcode: rx 0x41.
  - err pulse for 1 cycle, err_code=1, busy stays 0, no mem access.
- Timeout: TIMEOUT_CYCLES=20; rx 57 10, then idle for 25 cycles.
  - err with err_code=2 at cycle 20 after the 0x10 byte, state IDLE, no mem_we.
- Reset mid-burst: arst_n low while mem_re is pending and mem_rdy is held low.
  - mem_re=0, tx_valid=0, busy=0 immediately.
  - After release, rx 52 00 00 works normally.
